// File: rtl/fc_score_unit_if.sv
// -----------------------------------------------------------------------------
// fc_score_unit_if
//
// Purpose: groups the data-path buses of fc_score_unit into one bundle:
//   - feature stream  : feat_valid / feat_data / feat_ready
//   - weight memory   : w_rd / w_addr / w_data (synchronous, 1-cycle latency)
//   - score stream    : out_en / out_data (toward the argmax decoder)
//
// Handshake rules:
//   A feature beat transfers on every rising clk edge where feat_valid and
//   feat_ready are both 1. The producer holds feat_data stable while
//   feat_valid is high and not yet accepted. feat_ready depends only on the
//   unit's state, never on feat_valid. w_data must present the word at
//   w_addr one cycle after w_rd was high. out_en is a single-cycle pulse with
//   no back-pressure; out_data is valid while out_en=1 and holds afterwards.
//
// Modports:
//   slave  : the scoring unit itself
//   master : the environment (feature source, weight memory, score sink)
// -----------------------------------------------------------------------------
interface fc_score_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
);
  logic              feat_valid;
  logic [DATA_W-1:0] feat_data;
  logic              feat_ready;
  logic              w_rd;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic              out_en;
  logic [DATA_W-1:0] out_data;

  modport slave (
    input  feat_valid, feat_data, w_data,
    output feat_ready, w_rd, w_addr, out_en, out_data
  );

  modport master (
    output feat_valid, feat_data, w_data,
    input  feat_ready, w_rd, w_addr, out_en, out_data
  );
endinterface

// File: rtl/fc_score_unit.sv
// -----------------------------------------------------------------------------
// fc_score_unit
//
// Purpose: fully-connected output layer. Buffers one N_IN-element signed
// fixed-point feature vector, then for each of N_CLASS classes accumulates
// sum_i w(c,i)*x(i) + (b(c) <<< FRAC) in a wide accumulator, shifts the
// result right by FRAC (floor) and saturates it to DATA_W bits. Scores leave
// one per out_en pulse.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-low reset
//   start      begin a frame (honoured only while idle)
//   bus        fc_score_unit_if.slave: feature stream, weight memory port,
//              score output
//   busy       high from accepted start through the done cycle
//   done       one-cycle pulse after the last class score
//   dbg_state  current FSM state (IDLE=0, LOAD=1, MAC=2, OUT=3, DONE=4)
//
// Weight memory map: weight(c,i) at c*N_IN+i, bias(c) at N_CLASS*N_IN+c.
// -----------------------------------------------------------------------------
module fc_score_unit #(
  parameter int DATA_W  = 32,
  parameter int N_IN    = 16,
  parameter int N_CLASS = 10,
  parameter int FRAC    = 16,
  parameter int ADDR_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  fc_score_unit_if.slave        bus,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            dbg_state
);

  localparam int IW     = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int TW     = $clog2(N_IN + 2);
  localparam int CW     = (N_CLASS > 1) ? $clog2(N_CLASS) : 1;
  localparam int PROD_W = 2 * DATA_W;
  // Room for N_IN full-width products plus the shifted bias, plus sign.
  localparam int ACC_W  = 2 * DATA_W + $clog2(N_IN + 1) + 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_MAC  = 3'd2,
    S_OUT  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t state;
  state_t state_next;

  logic [IW-1:0]           k;        // next feature slot to fill
  logic [TW-1:0]           t;        // local MAC cycle within a class
  logic [CW-1:0]           c;        // current class
  logic signed [ACC_W-1:0] acc;
  logic [DATA_W-1:0]       score_q;
  logic [DATA_W-1:0]       feat_buf [N_IN];

  logic accept;
  logic last_beat;
  logic mac_last;
  logic last_class;

  assign accept     = (state == S_LOAD) && bus.feat_valid;
  assign last_beat  = (k == IW'(N_IN - 1));
  assign mac_last   = (t == TW'(N_IN + 1));
  assign last_class = (c == CW'(N_CLASS - 1));

  // ---------------------------------------------------------------------------
  // FSM: state register and next-state logic
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_LOAD;
      S_LOAD:  if (accept && last_beat) state_next = S_MAC;
      S_MAC:   if (mac_last) state_next = S_OUT;
      S_OUT:   state_next = last_class ? S_DONE : S_MAC;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs decoded from registered state only
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.feat_ready = (state == S_LOAD);
    bus.out_en     = (state == S_OUT);
    bus.out_data   = score_q;
    busy           = (state != S_IDLE);
    done           = (state == S_DONE);
    dbg_state      = state;
    bus.w_rd       = 1'b0;
    bus.w_addr     = '0;
    if (state == S_MAC) begin
      if (t < TW'(N_IN)) begin
        bus.w_rd   = 1'b1;
        bus.w_addr = ADDR_W'(int'(c) * N_IN + int'(t));
      end else if (t == TW'(N_IN)) begin
        bus.w_rd   = 1'b1;
        bus.w_addr = ADDR_W'(N_CLASS * N_IN + int'(c));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Arithmetic. w_data read at t-1 arrives at t, so the weight for feature
  // t-1 is consumed at t=1..N_IN and the bias at t=N_IN+1.
  // ---------------------------------------------------------------------------
  logic [IW-1:0]            buf_idx;
  logic signed [PROD_W-1:0] w_ext;
  logic signed [PROD_W-1:0] x_ext;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  term;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [ACC_W-1:0]  shifted;
  logic                     fits;
  logic [DATA_W-1:0]        score;

  assign buf_idx = IW'(t - TW'(1));
  assign w_ext   = PROD_W'($signed(bus.w_data));
  assign x_ext   = PROD_W'($signed(feat_buf[buf_idx]));
  assign prod    = w_ext * x_ext;

  always_comb begin
    if (mac_last) begin
      term = ACC_W'($signed(bus.w_data)) <<< FRAC;
    end else begin
      term = ACC_W'(prod);
    end
  end

  assign acc_sum = acc + term;
  assign shifted = acc_sum >>> FRAC;

  // The score fits when every bit above the DATA_W sign bit repeats it.
  assign fits = (&shifted[ACC_W-1:DATA_W-1]) || (~|shifted[ACC_W-1:DATA_W-1]);

  always_comb begin
    if (fits) begin
      score = shifted[DATA_W-1:0];
    end else if (shifted[ACC_W-1]) begin
      score = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      score = {1'b0, {(DATA_W-1){1'b1}}};
    end
  end

  // ---------------------------------------------------------------------------
  // Counters, accumulator and score register. The score is captured on the
  // last MAC edge (including the bias) so it is already valid during the OUT
  // cycle that pulses out_en.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      k       <= '0;
      t       <= '0;
      c       <= '0;
      acc     <= '0;
      score_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          k <= '0;
          t <= '0;
          c <= '0;
        end
        S_LOAD: begin
          if (accept) begin
            k <= last_beat ? '0 : k + 1'b1;
          end
        end
        S_MAC: begin
          if (t == '0) begin
            acc <= '0;
          end else begin
            acc <= acc_sum;
          end
          if (mac_last) begin
            t       <= '0;
            score_q <= score;
          end else begin
            t <= t + 1'b1;
          end
        end
        S_OUT: begin
          if (!last_class) begin
            c <= c + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Feature buffer: contents are don't-care after reset, so no reset term.
  always_ff @(posedge clk) begin
    if (rst && accept) begin
      feat_buf[k] <= bus.feat_data;
    end
  end

endmodule

// File: tb/tb_fc_score_unit.sv
// -----------------------------------------------------------------------------
// tb_fc_score_unit
//
// Two instances: dut_a (N_IN=4, N_CLASS=3, FRAC=0) and dut_b (N_IN=1,
// N_CLASS=2, FRAC=16). Drivers push expected scores into exp_a/exp_b; the
// negedge monitors pop and compare on every out_en and check pulse timing.
// -----------------------------------------------------------------------------
module tb_fc_score_unit;
  localparam int W     = 32;
  localparam int NA_IN = 4;
  localparam int NA_CL = 3;
  localparam int FA    = 0;
  localparam int NB_IN = 1;
  localparam int NB_CL = 2;
  localparam int FB    = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start_a, start_b;
  logic       busy_a, done_a, busy_b, done_b;
  logic [2:0] dbg_a, dbg_b;

  fc_score_unit_if #(.DATA_W(W), .ADDR_W(8)) bus_a ();
  fc_score_unit_if #(.DATA_W(W), .ADDR_W(8)) bus_b ();

  fc_score_unit #(.DATA_W(W), .N_IN(NA_IN), .N_CLASS(NA_CL), .FRAC(FA), .ADDR_W(8)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .bus(bus_a),
    .busy(busy_a), .done(done_a), .dbg_state(dbg_a)
  );

  fc_score_unit #(.DATA_W(W), .N_IN(NB_IN), .N_CLASS(NB_CL), .FRAC(FB), .ADDR_W(8)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .bus(bus_b),
    .busy(busy_b), .done(done_b), .dbg_state(dbg_b)
  );

  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memories (1-cycle read latency, garbage when idle) ----------------
  logic [W-1:0] mem_a [256];
  logic [W-1:0] mem_b [256];
  logic [W-1:0] xa [16];
  logic [W-1:0] xb [16];

  always @(posedge clk) begin
    bus_a.w_data <= bus_a.w_rd ? mem_a[bus_a.w_addr] : W'($urandom);
    bus_b.w_data <= bus_b.w_rd ? mem_b[bus_b.w_addr] : W'($urandom);
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_a[$];
  logic [W-1:0] exp_b[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: exact integer dot product, floor shift, clamp to DATA_W range.
  function automatic logic [W-1:0] model(input int n_in, input int frac, input int n_cl,
                                         input int c, input logic [W-1:0] xv [16],
                                         input logic [W-1:0] mv [256]);
    logic signed [127:0] s, a, b;
    s = '0;
    for (int i = 0; i < n_in; i++) begin
      a = $signed(mv[c * n_in + i]);
      b = $signed(xv[i]);
      s = s + a * b;
    end
    a = $signed(mv[n_cl * n_in + c]);
    s = s + (a <<< frac);
    s = s >>> frac;
    if (s > 128'sh7FFFFFFF) return 32'h7FFFFFFF;
    if (s < -128'sh80000000) return 32'h80000000;
    return s[W-1:0];
  endfunction

  // ---------------- monitors ----------------
  int unsigned last_out_a = 0, last_acc_a = 0;
  int          pulses_a = 0, beats_a = 0, frames_a = 0;
  int          pulses_b = 0, frames_b = 0;

  always @(negedge clk) begin
    if (!rst) begin
      pulses_a = 0;
      beats_a  = 0;
    end else begin
      if (!bus_a.w_rd) check("a_addr_idle", bus_a.w_addr, 0);
      if (bus_a.feat_valid && bus_a.feat_ready) begin
        beats_a++;
        last_acc_a = cyc;
      end
      if (bus_a.out_en) begin
        if (exp_a.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL a_unexpected_out actual=%0h required=no_pulse", bus_a.out_data);
        end else begin
          check("a_score", bus_a.out_data, exp_a.pop_front());
        end
        if (pulses_a == 0) check("a_first_latency", cyc - last_acc_a, NA_IN + 3);
        else               check("a_out_gap", cyc - last_out_a, NA_IN + 3);
        pulses_a++;
        last_out_a = cyc;
      end
      if (done_a) begin
        check("a_done_gap", cyc - last_out_a, 1);
        check("a_pulses", pulses_a, NA_CL);
        check("a_beats", beats_a, NA_IN);
        pulses_a = 0;
        beats_a  = 0;
        frames_a++;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      pulses_b = 0;
    end else begin
      if (bus_b.out_en) begin
        if (exp_b.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL b_unexpected_out actual=%0h required=no_pulse", bus_b.out_data);
        end else begin
          check("b_score", bus_b.out_data, exp_b.pop_front());
        end
        pulses_b++;
      end
      if (done_b) begin
        check("b_pulses", pulses_b, NB_CL);
        pulses_b = 0;
        frames_b++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_a(input string tag);
    check({tag, "_busy"},     busy_a, 0);
    check({tag, "_done"},     done_a, 0);
    check({tag, "_ready"},    bus_a.feat_ready, 0);
    check({tag, "_w_rd"},     bus_a.w_rd, 0);
    check({tag, "_w_addr"},   bus_a.w_addr, 0);
    check({tag, "_out_en"},   bus_a.out_en, 0);
    check({tag, "_out_data"}, bus_a.out_data, 0);
    check({tag, "_state"},    dbg_a, 0);
  endtask

  task automatic load_basic();
    for (int i = 0; i < 16; i++) xa[i] = '0;
    for (int i = 0; i < 256; i++) mem_a[i] = '0;
    for (int i = 0; i < NA_IN; i++) xa[i] = W'(i + 1);
    for (int i = 0; i < 4; i++) mem_a[i] = 32'd1;        // w0 = {1,1,1,1}
    mem_a[4]  = 32'hFFFF_FFFF;                           // w1 = {-1,0,0,0}
    mem_a[11] = 32'd2;                                   // w2 = {0,0,0,2}
    mem_a[12] = 32'd0;                                   // b0
    mem_a[13] = 32'd5;                                   // b1
    mem_a[14] = 32'hFFFF_FFFD;                           // b2 = -3
  endtask

  task automatic push_basic();
    exp_a.push_back(32'd10);
    exp_a.push_back(32'd4);
    exp_a.push_back(32'd5);
  endtask

  // gaps: valid on alternate cycles; extra: beats offered after the frame;
  // abort_t >= 0: reset at that MAC cycle; use_model: push model scores.
  task automatic run_frame_a(input bit gaps, input int extra, input int abort_t,
                             input bit start_in_mac, input bit use_model);
    int  sent, guard, f0;
    bit  acc_now;
    if (use_model && abort_t < 0)
      for (int c = 0; c < NA_CL; c++) exp_a.push_back(model(NA_IN, FA, NA_CL, c, xa, mem_a));
    f0 = frames_a;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    sent  = 0;
    guard = 0;
    while (sent < NA_IN && guard < 200) begin
      bus_a.feat_valid = gaps ? (guard % 2 == 0) : 1'b1;
      bus_a.feat_data  = xa[sent];
      acc_now = bus_a.feat_valid && bus_a.feat_ready;
      tick();
      if (acc_now) sent++;
      guard++;
    end
    check("a_load_done", sent, NA_IN);
    for (int e = 0; e < extra; e++) begin
      bus_a.feat_valid = 1'b1;
      bus_a.feat_data  = W'($urandom);
      tick();
    end
    bus_a.feat_valid = 1'b0;
    if (abort_t >= 0) begin
      for (int i = 0; i < abort_t; i++) tick();
      rst = 1'b0;
      tick();
      check_idle_a("abort");
      rst = 1'b1;
      tick();
      return;
    end
    if (start_in_mac) begin
      tick();
      tick();
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
    end
    guard = 0;
    while (frames_a == f0 && guard < 1000) begin
      tick();
      guard++;
    end
    check("a_frame_finished", frames_a != f0, 1);
    check("a_idle_after_done", busy_a, 0);
    check("a_state_after_done", dbg_a, 0);
  endtask

  task automatic run_frame_b(input bit use_model);
    int guard, f0;
    if (use_model)
      for (int c = 0; c < NB_CL; c++) exp_b.push_back(model(NB_IN, FB, NB_CL, c, xb, mem_b));
    f0 = frames_b;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    bus_b.feat_valid = 1'b1;
    bus_b.feat_data  = xb[0];
    guard = 0;
    while (!bus_b.feat_ready && guard < 20) begin
      tick();
      guard++;
    end
    tick();
    bus_b.feat_valid = 1'b0;
    guard = 0;
    while (frames_b == f0 && guard < 200) begin
      tick();
      guard++;
    end
    check("b_frame_finished", frames_b != f0, 1);
    check("b_idle_after_done", busy_b, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    bus_a.feat_valid = 1'b0;
    bus_a.feat_data  = '0;
    bus_b.feat_valid = 1'b0;
    bus_b.feat_data  = '0;

    // Reset held for 3 cycles while inputs toggle.
    for (int i = 0; i < 3; i++) begin
      start_a = i[0] ? 1'b0 : 1'b1;
      bus_a.feat_valid = i[0];
      start_b = 1'b1;
      tick();
      check_idle_a("rst");
      check("rst_b_busy", busy_b, 0);
    end
    start_a = 1'b0;
    start_b = 1'b0;
    bus_a.feat_valid = 1'b0;
    rst = 1'b1;
    tick();

    // Basic frame: scores 10, 4, 5.
    load_basic();
    push_basic();
    run_frame_a(1'b0, 0, -1, 1'b0, 1'b0);

    // Backpressure with 2 extra beats: same scores.
    push_basic();
    run_frame_a(1'b1, 2, -1, 1'b0, 1'b0);

    // Positive saturation.
    for (int i = 0; i < NA_IN; i++) xa[i] = 32'h7FFF_FFFF;
    for (int i = 0; i < NA_CL * (NA_IN + 1); i++) mem_a[i] = 32'h7FFF_FFFF;
    for (int c = 0; c < NA_CL; c++) exp_a.push_back(32'h7FFF_FFFF);
    run_frame_a(1'b0, 0, -1, 1'b0, 1'b0);

    // Negative saturation.
    for (int i = 0; i < NA_CL * (NA_IN + 1); i++) mem_a[i] = 32'h8000_0000;
    for (int c = 0; c < NA_CL; c++) exp_a.push_back(32'h8000_0000);
    run_frame_a(1'b0, 0, -1, 1'b0, 1'b0);

    // start during MAC is ignored.
    load_basic();
    push_basic();
    run_frame_a(1'b0, 0, -1, 1'b1, 1'b0);

    // Reset at MAC t=2, then a fresh frame.
    run_frame_a(1'b0, 0, 2, 1'b0, 1'b0);
    push_basic();
    run_frame_a(1'b0, 0, -1, 1'b0, 1'b0);

    // Randomized frames: small and full-range operands.
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < NA_IN; i++)
        xa[i] = f[0] ? W'($urandom) : W'($urandom_range(0, 2000)) - 32'd1000;
      for (int i = 0; i < NA_CL * (NA_IN + 1); i++)
        mem_a[i] = f[1] ? W'($urandom) : W'($urandom_range(0, 2000)) - 32'd1000;
      run_frame_a(f[2], $urandom_range(0, 2), -1, 1'b0, 1'b1);
    end

    // Fixed point: 1.5*2.0-0.5 = 2.5 and 1.5*(-1.0)+1.0 = -0.5.
    xb[0]    = 32'h0001_8000;
    mem_b[0] = 32'h0002_0000;
    mem_b[1] = 32'hFFFF_0000;
    mem_b[2] = 32'hFFFF_8000;
    mem_b[3] = 32'h0001_0000;
    exp_b.push_back(32'h0002_8000);
    exp_b.push_back(32'hFFFF_8000);
    run_frame_b(1'b0);

    for (int f = 0; f < 6; f++) begin
      xb[0] = f[0] ? W'($urandom) : W'($urandom_range(0, 32'h0004_0000)) - 32'h0002_0000;
      for (int i = 0; i < 4; i++)
        mem_b[i] = f[1] ? W'($urandom) : W'($urandom_range(0, 32'h0004_0000)) - 32'h0002_0000;
      run_frame_b(1'b1);
    end

    tick();
    check("a_queue_empty", exp_a.size(), 0);
    check("b_queue_empty", exp_b.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fc_score_unit.md
# fc_score_unit

Fully-connected output layer that turns one flattened feature vector into one signed score per class. It streams those scores, one per pulse, into the argmax index decoder stage via `out_en`/`out_data`. Features arrive over a valid/ready stream and are buffered internally. Weights and biases are fetched from an external synchronous ROM/SRAM (1-cycle read latency), and the products are accumulated in wide fixed-point arithmetic. Each score is saturated to `DATA_W` bits.

## Interface

Parameters:
- `DATA_W`, 32: width of features, weights, biases, scores (matches `INTERNAL_BITS`).
- `N_IN`, 16: features per vector (≥1).
- `N_CLASS`, 10: number of output classes (≥1).
- `FRAC`, 16: fractional bits of the signed fixed-point format (0..DATA_W-1).
- `ADDR_W`, 8: weight-memory address width; must satisfy 2^ADDR_W ≥ N_CLASS*(N_IN+1).

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; synchronous, active-low (0 = reset, sampled on `clk` rising edge).
- `start`  in  1  begin a frame; honoured only in IDLE.
- `feat_valid`  in  1  feature beat valid.
- `feat_data`  in  DATA_W  signed feature.
- `feat_ready`  out  1  high only in LOAD.
- `w_rd`  out  1  memory read strobe.
- `w_addr`  out  ADDR_W  read address.
- `w_data`  in  DATA_W  signed read data, valid the cycle after `w_rd`.
- `out_en`  out  1  one-cycle pulse, score valid.
- `out_data`  out  DATA_W  signed saturated score; holds its value between pulses.
- `busy`  out  1  high from accepted `start` through the `done` cycle.
- `done`  out  1  one-cycle pulse after the last class score.

## Operation

- Memory map: weight(c,i) is at `c*N_IN + i`; bias(c) is at `N_CLASS*N_IN + c`.
- FSM states are IDLE, LOAD, MAC, OUT, DONE.
- IDLE: `feat_ready`=0. On `start`=1, go to LOAD and set `busy`=1.
- LOAD: `feat_ready`=1. Each `feat_valid & feat_ready` cycle writes `feat_data` into buffer[k] and increments k.
  - After beat N_IN-1 is accepted, go to MAC with class c=0. `feat_ready` is low the next cycle.
  - Extra beats are never accepted.
- MAC, per class c, using local cycle t:
  - t=0..N_IN-1: `w_rd`=1, `w_addr`=weight(c,t).
  - t=N_IN: `w_rd`=1, `w_addr`=bias(c).
  - t=1..N_IN: acc += w_data * buffer[t-1].
  - t=N_IN+1: acc += w_data <<< FRAC (the bias term).
  - acc is cleared at t=0 of every class. Then go to OUT.
- OUT: form the score from acc (rule below), pulse `out_en`, register `out_data`.
  - If c<N_CLASS-1: increment c and return to MAC.
  - Otherwise go to DONE.
- DONE: `done`=1 for one cycle, then IDLE with `busy`=0.
- `start` is ignored while `busy`=1.
- Arithmetic:
  - Products are full 2*DATA_W signed.
  - acc width is 2*DATA_W + clog2(N_IN+1) + 1 and never overflows.
  - score = acc >>> FRAC (arithmetic shift, truncation toward −inf).
  - score is saturated to [−2^(DATA_W-1), 2^(DATA_W-1)−1].
- Reset (`rst`=0 at a clock edge), including mid-frame:
  - Next state is IDLE.
  - `feat_ready`, `w_rd`, `out_en`, `busy`, `done` are all 0.
  - `w_addr`=0, `out_data`=0.
  - acc, c and k are cleared. Buffer contents are don't-care.
- `w_addr` is 0 whenever `w_rd`=0.

## Timing

- Class period is exactly N_IN+3 cycles (N_IN+2 MAC cycles plus 1 OUT cycle). `out_en` pulses are spaced by exactly N_IN+3 cycles.
- First `w_rd` occurs the cycle after the last feature beat is accepted.
- First `out_en` occurs N_IN+2 cycles after the first `w_rd`.
- `done` occurs the cycle after the last `out_en`.
- Frame latency from last feature accepted to `done` = N_CLASS*(N_IN+3)+1 cycles.
- `start` asserted in the DONE cycle is ignored; it is accepted from IDLE the following cycle.
- The downstream decoder restarts its index count per frame. The top level clears the decoder using `done`, or starts it using `start`.

## Test plan

- Reset:
  - Stimulus: hold `rst`=0 for 3 cycles while toggling `start`/`feat_valid`.
  - Required: all outputs 0; `busy` stays 0.
- Basic frame (N_IN=4, N_CLASS=3, FRAC=0):
  - Stimulus: x={1,2,3,4}; w0={1,1,1,1}, b0=0; w1={−1,0,0,0}, b1=5; w2={0,0,0,2}, b2=−3.
  - Required: `out_data` 10, 4, 5; `out_en` pulses 7 cycles apart; `done` 1 cycle after the third pulse.
- Saturation (FRAC=0):
  - Stimulus: all x and w = 0x7FFFFFFF.
  - Required: score 0x7FFFFFFF.
  - Stimulus: x=0x7FFFFFFF, w=0x80000000.
  - Required: score 0x80000000.
- Fixed point (FRAC=16, N_IN=1):
  - Stimulus: x=0x00018000 (1.5), w=0x00020000 (2.0), b=0xFFFF8000 (−0.5).
  - Required: score 0x00028000 (2.5).
- Backpressure:
  - Stimulus: `feat_valid` high on alternating cycles, plus 2 extra beats after N_IN.
  - Required: same scores as the basic-frame case; `feat_ready` low after beat N_IN-1; extra beats not consumed.
- Control hazards:
  - Stimulus: `start` pulsed during MAC.
  - Required: ignored.
  - Stimulus: `rst`=0 at MAC t=2.
  - Required: IDLE next cycle; no `out_en`; a fresh frame then produces the correct scores.
